nibble_serial_adder_ctrl: RTL

Multi-cycle sequencer that adds two WIDTH-bit operands by reusing a single 4-bit ripple-carry adder slice once per nibble, LSB nibble first. The carry is registered between nibbles. It sits in front of the shared 4-bit adder datapath and gives wider-word software/test logic a valid/ready interface. It exists so wide additions cost one 4-bit slice plus control, not WIDTH/4 slices.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 17 +
 rtl/nibble_serial_adder_ctrl_slice.sv | 29 ++
 rtl/nibble_serial_adder_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial adder controller.
// Nibble width, FSM state encoding and nibble count.
package adder_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nibbles(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// Combinational 4-bit ripple-carry adder slice.
// c3 is the carry into the top bit, used for signed overflow.
module add4_slice
  import adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             c3
);

  logic [NIB_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[NIB_W];
  assign c3   = c[NIB_W-1];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice, one nibble per cycle.
// Define ADD_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = nibbles(WIDTH);
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_e                  state;
  logic [NIB-1:0][NIB_W-1:0] a_q;
  logic [NIB-1:0][NIB_W-1:0] b_q;
  logic [NIB-1:0][NIB_W-1:0] sum_q;
  logic [IW-1:0]           idx;
  logic                    carry_q;
  logic                    cout_q;
  logic [NIB_W-1:0]        s;
  logic                    co;
  logic                    last;

`ifdef ADD_OVF_EN
  logic c3;
  logic ovf_q;
`else
  logic unused_c3;
`endif

  add4_slice u_slice (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry_q),
    .s    (s),
    .cout (co),
`ifdef ADD_OVF_EN
    .c3   (c3)
`else
    .c3   (unused_c3)
`endif
  );

  assign last = (idx == IW'(NIB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= s;
          carry_q    <= co;
          idx        <= idx + IW'(1);
          if (last) begin
            cout_q <= co;
`ifdef ADD_OVF_EN
            ovf_q  <= c3 ^ co;
`endif
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
`ifdef ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
